// File: rtl/memory_bus_responder_if.sv
// MemoryBus request/response mailbox signals between the bus (master) and
// the memory-side responder (slave).
interface memory_bus_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 4
);
  logic              req_busy;
  logic [1:0]        req_type;
  logic [SRC_W-1:0]  req_source;
  logic [ADDR_W-1:0] req_address;
  logic [DATA_W-1:0] req_payload;
  logic              req_accept;
  logic              rsp_busy;
  logic              rsp_send;
  logic [1:0]        rsp_type;
  logic [SRC_W-1:0]  rsp_source;
  logic [ADDR_W-1:0] rsp_address;
  logic [DATA_W-1:0] rsp_payload;

  modport master (
    output req_busy, req_type, req_source, req_address, req_payload, rsp_busy,
    input  req_accept, rsp_send, rsp_type, rsp_source, rsp_address, rsp_payload
  );

  modport slave (
    input  req_busy, req_type, req_source, req_address, req_payload, rsp_busy,
    output req_accept, rsp_send, rsp_type, rsp_source, rsp_address, rsp_payload
  );
endinterface

// File: rtl/memory_bus_responder.sv
// Memory-side endpoint of the single-slot MemoryBus mailbox: one packet in flight,
// fixed-latency word RAM. Define MEMORY_BUS_WRITE_ACK_EN to answer writes with write_ack.
module memory_bus_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SRC_W       = 4,
  parameter int DEPTH       = 1024,
  parameter int MEM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  memory_bus_responder_if.slave  bus,
  output logic                   busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [1:0] T_READ  = 2'd0;
  localparam logic [1:0] T_WRITE = 2'd1;
  localparam logic [1:0] T_RRSP  = 2'd2;
  localparam logic [1:0] T_WACK  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_take;
  logic               w_access;
  logic               w_send;
  logic               w_ram_we;

  logic [1:0]         r_type;
  logic [SRC_W-1:0]   r_src;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_payload;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               r_req_accept;
  logic               r_rsp_send;
  logic [1:0]         r_rsp_type;
  logic [SRC_W-1:0]   r_rsp_source;
  logic [DATA_W-1:0]  r_rsp_payload;

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_access    = 1'b0;
    w_send      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_busy) begin
          w_take      = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_cnt == '0) begin
          w_access = 1'b1;
          case (r_type)
            T_READ:  w_state_nxt = S_RESPOND;
`ifdef MEMORY_BUS_WRITE_ACK_EN
            T_WRITE: w_state_nxt = S_RESPOND;
`else
            T_WRITE: w_state_nxt = S_IDLE;
`endif
            // Response types arriving in the request slot are dropped silently.
            T_RRSP, T_WACK: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_RESPOND: begin
        if (!bus.rsp_busy) begin
          w_send      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_req_accept <= 1'b0;
      r_rsp_send   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_accept <= w_take;
      r_rsp_send   <= w_send;
      if (w_take) begin
        r_cnt <= CNT_W'(MEM_LATENCY - 1);
      end else if (r_state == S_ACCESS && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Captured packet; upper address bits are dropped so addresses alias modulo DEPTH.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_type    <= bus.req_type;
      r_src     <= bus.req_source;
      r_idx     <= IDX_W'(bus.req_address);
      r_payload <= bus.req_payload;
    end
  end

  // A write that is in flight when reset arrives must not reach the RAM.
  assign w_ram_we = w_access && !reset && (r_type == T_WRITE);

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[r_idx] <= r_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_type    <= 2'd0;
      r_rsp_source  <= '0;
      r_rsp_payload <= '0;
    end else if (w_access) begin
      if (r_type == T_READ) begin
        r_rsp_type    <= T_RRSP;
        r_rsp_source  <= r_src;
        r_rsp_payload <= r_mem[r_idx];
      end
`ifdef MEMORY_BUS_WRITE_ACK_EN
      else if (r_type == T_WRITE) begin
        r_rsp_type    <= T_WACK;
        r_rsp_source  <= r_src;
        r_rsp_payload <= r_payload;
      end
`endif
    end
  end

  assign bus.req_accept  = r_req_accept;
  assign bus.rsp_send    = r_rsp_send;
  assign bus.rsp_type    = r_rsp_type;
  assign bus.rsp_source  = r_rsp_source;
  assign bus.rsp_address = '0;
  assign bus.rsp_payload = r_rsp_payload;
  assign busy_o          = (r_state != S_IDLE);

endmodule

// File: tb/tb_memory_bus_responder.sv
// Bench for memory_bus_responder: directed vector table, reset/back-pressure
// sequences, then random traffic against an abstract memory model.
module tb_memory_bus_responder;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 4;
  localparam int DEPTH  = 1024;
  localparam int LAT    = 2;
`ifdef MEMORY_BUS_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy_o;

  memory_bus_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) bus ();

  memory_bus_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W),
    .DEPTH(DEPTH), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Results of the last transaction, as observed on the bus.
  int                n_acc, acc_c, n_snd, snd_c;
  logic [1:0]        o_type;
  logic [SRC_W-1:0]  o_src;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_pay;
  logic              busy_end;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Send latency seen by the bus: E+LAT+2, delayed while rsp_busy is held.
  function automatic int exp_send_cycle(input int hold);
    return imax(LAT + 2, hold + 1);
  endfunction

  // Presents one packet, acts as the bus (clears req_busy on accept, holds
  // rsp_busy for 'hold' cycles) and records what the responder did.
  task automatic run_txn(input logic [1:0] t, input logic [SRC_W-1:0] s,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] p,
                         input int hold);
    int last;
    @(posedge clk); #1;
    bus.req_busy    = 1'b1;
    bus.req_type    = t;
    bus.req_source  = s;
    bus.req_address = a;
    bus.req_payload = p;
    bus.rsp_busy    = (hold > 0);
    @(posedge clk);
    n_acc = 0; acc_c = -1; n_snd = 0; snd_c = -1;
    o_type = 'x; o_src = 'x; o_addr = 'x; o_pay = 'x;
    last = exp_send_cycle(hold) + 3;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (bus.req_accept) begin
        n_acc++;
        acc_c = c;
        bus.req_busy = 1'b0;
      end
      if (bus.rsp_send) begin
        n_snd++;
        snd_c  = c;
        o_type = bus.rsp_type;
        o_src  = bus.rsp_source;
        o_addr = bus.rsp_address;
        o_pay  = bus.rsp_payload;
      end
      bus.rsp_busy = (c < hold);
      busy_end = busy_o;
    end
    bus.req_busy = 1'b0;
    bus.rsp_busy = 1'b0;
  endtask

  task automatic check_txn(input string tag, input int hold, input bit es,
                           input logic [1:0] et, input logic [SRC_W-1:0] esrc,
                           input logic [DATA_W-1:0] ep);
    chk({tag, ".accept_count"}, 64'(n_acc), 64'd1);
    chk({tag, ".accept_cycle"}, 64'(acc_c), 64'd1);
    chk({tag, ".send_count"}, 64'(n_snd), 64'(es));
    chk({tag, ".busy_at_end"}, 64'(busy_end), 64'd0);
    if (es) begin
      chk({tag, ".send_cycle"}, 64'(snd_c), 64'(exp_send_cycle(hold)));
      chk({tag, ".rsp_type"}, 64'(o_type), 64'(et));
      chk({tag, ".rsp_source"}, 64'(o_src), 64'(esrc));
      chk({tag, ".rsp_address"}, 64'(o_addr), 64'd0);
      chk({tag, ".rsp_payload"}, 64'(o_pay), 64'(ep));
    end
  endtask

  // Behavioural memory: index = address modulo DEPTH.
  logic [DATA_W-1:0] model_mem [int];
  int                written_q [$];

  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] p);
    int idx;
    idx = int'(a % DEPTH);
    if (!model_mem.exists(idx)) written_q.push_back(idx);
    model_mem[idx] = p;
  endtask

  typedef struct {
    logic [1:0]        t;
    logic [SRC_W-1:0]  s;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] p;
    int                hold;
    bit                es;
    logic [1:0]        et;
    logic [DATA_W-1:0] ep;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{2'd1, 4'd3, 32'h0000_0005, 32'hDEAD_BEEF, 0,  ACK,  2'd3, 32'hDEAD_BEEF};
    vecs[1]  = '{2'd0, 4'd3, 32'h0000_0005, 32'h0,         0,  1'b1, 2'd2, 32'hDEAD_BEEF};
    vecs[2]  = '{2'd0, 4'd7, 32'h0000_0005, 32'h0,         10, 1'b1, 2'd2, 32'hDEAD_BEEF};
    vecs[3]  = '{2'd1, 4'd2, 32'h0000_0405, 32'h0000_0007, 0,  ACK,  2'd3, 32'h0000_0007};
    vecs[4]  = '{2'd0, 4'd1, 32'h0000_0005, 32'h0,         0,  1'b1, 2'd2, 32'h0000_0007};
    vecs[5]  = '{2'd2, 4'd4, 32'h0000_0005, 32'h0000_0099, 0,  1'b0, 2'd0, 32'h0};
    vecs[6]  = '{2'd3, 4'd4, 32'h0000_0005, 32'h0000_00AA, 0,  1'b0, 2'd0, 32'h0};
    vecs[7]  = '{2'd0, 4'd9, 32'hFFFF_FC05, 32'h0,         0,  1'b1, 2'd2, 32'h0000_0007};
    vecs[8]  = '{2'd1, 4'd6, 32'h0000_0009, 32'h0000_0055, 0,  ACK,  2'd3, 32'h0000_0055};
    vecs[9]  = '{2'd0, 4'd15, 32'h0000_03FF, 32'h0,        0,  1'b0, 2'd0, 32'h0};
    vecs[10] = '{2'd0, 4'd6, 32'h0000_0009, 32'h0,         4,  1'b1, 2'd2, 32'h0000_0055};
    // vecs[9] is replaced below by a write so every read hits a written word.
    vecs[9]  = '{2'd1, 4'd15, 32'h0000_03FF, 32'h1234_5678, 5, ACK,  2'd3, 32'h1234_5678};

    bus.req_busy = 1'b0; bus.req_type = 2'd0; bus.req_source = '0;
    bus.req_address = '0; bus.req_payload = '0; bus.rsp_busy = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.req_accept", 64'(bus.req_accept), 64'd0);
    chk("reset.rsp_send", 64'(bus.rsp_send), 64'd0);
    chk("reset.busy_o", 64'(busy_o), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].t, vecs[i].s, vecs[i].a, vecs[i].p, vecs[i].hold);
      check_txn($sformatf("vec%0d", i), vecs[i].hold, vecs[i].es, vecs[i].et,
                vecs[i].s, vecs[i].ep);
      if (vecs[i].t == 2'd1) model_write(vecs[i].a, vecs[i].p);
    end

    // Reset for two cycles while a read is in ACCESS: the read is dropped.
    @(posedge clk); #1;
    bus.req_busy = 1'b1; bus.req_type = 2'd0; bus.req_source = 4'd3;
    bus.req_address = 32'h5; bus.req_payload = '0; bus.rsp_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset.accept", 64'(bus.req_accept), 64'd1);
    chk("midreset.busy_before", 64'(busy_o), 64'd1);
    bus.req_busy = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midreset.busy_o", 64'(busy_o), 64'd0);
    chk("midreset.rsp_payload", 64'(bus.rsp_payload), 64'd0);
    chk("midreset.rsp_type", 64'(bus.rsp_type), 64'd0);
    chk("midreset.rsp_source", 64'(bus.rsp_source), 64'd0);
    chk("midreset.req_accept", 64'(bus.req_accept), 64'd0);
    reset = 1'b0;
    n_snd = 0; n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.rsp_send) n_snd++;
      if (bus.req_accept || busy_o) n_acc++;
    end
    chk("midreset.no_send_after", 64'(n_snd), 64'd0);
    chk("midreset.stays_idle", 64'(n_acc), 64'd0);

    // Random traffic against the model; reads target words already written.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]        t;
      logic [SRC_W-1:0]  s;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] p;
      int                hold, sel, idx;
      bit                es;
      logic [1:0]        et;
      logic [DATA_W-1:0] ep;
      sel  = $urandom_range(0, 9);
      s    = SRC_W'($urandom);
      p    = $urandom;
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : 0;
      if (sel < 5) begin
        idx = written_q[$urandom_range(0, written_q.size() - 1)];
        a   = ($urandom & ~(ADDR_W'(DEPTH - 1))) | ADDR_W'(idx);
        t   = 2'd0;
        es  = 1'b1; et = 2'd2; ep = model_mem[idx];
      end else if (sel < 9) begin
        a  = $urandom;
        t  = 2'd1;
        es = ACK; et = 2'd3; ep = p;
      end else begin
        a  = $urandom;
        t  = 2'($urandom_range(2, 3));
        es = 1'b0; et = 2'd0; ep = '0;
      end
      run_txn(t, s, a, p, hold);
      check_txn($sformatf("rnd%0d", i), hold, es, et, s, ep);
      if (t == 2'd1) model_write(a, p);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
